// File: rtl/unidade_de_controle_multiciclo_pkg.sv
// Shared encodings for the iZero multicycle control unit: ISA fields, ALU codes,
// mux selects, FSM states and the latched instruction class.
package unidade_de_controle_multiciclo_pkg;

  localparam int OP_W_DEF    = 6;
  localparam int FUNC_W_DEF  = 6;
  localparam int ALUOP_W_DEF = 5;

  // opcodes
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_SUBI = 6'd2;
  localparam logic [5:0] OP_MULI = 6'd3;
  localparam logic [5:0] OP_DIVI = 6'd4;
  localparam logic [5:0] OP_MODI = 6'd5;
  localparam logic [5:0] OP_ANDI = 6'd6;
  localparam logic [5:0] OP_EQI  = 6'd7;
  localparam logic [5:0] OP_LTI  = 6'd8;
  localparam logic [5:0] OP_LI   = 6'd9;
  localparam logic [5:0] OP_LA   = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd16;
  localparam logic [5:0] OP_SW   = 6'd17;
  localparam logic [5:0] OP_J    = 6'd24;
  localparam logic [5:0] OP_JAL  = 6'd25;
  localparam logic [5:0] OP_JR   = 6'd26;
  localparam logic [5:0] OP_JF   = 6'd27;
  localparam logic [5:0] OP_IN   = 6'd32;
  localparam logic [5:0] OP_OUT  = 6'd33;
  localparam logic [5:0] OP_HALT = 6'd62;
  localparam logic [5:0] OP_NOP  = 6'd63;

  // R-type func field
  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_SUB = 6'd1;
  localparam logic [5:0] F_MUL = 6'd2;
  localparam logic [5:0] F_DIV = 6'd3;
  localparam logic [5:0] F_MOD = 6'd4;
  localparam logic [5:0] F_AND = 6'd8;
  localparam logic [5:0] F_MOV = 6'd14;
  localparam logic [5:0] F_EQ  = 6'd16;
  localparam logic [5:0] F_LT  = 6'd18;

  // ALU control, same for register and immediate forms
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00010;
  localparam logic [4:0] ALU_DIV = 5'b00011;
  localparam logic [4:0] ALU_MOD = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b01000;
  localparam logic [4:0] ALU_MOV = 5'b01110;
  localparam logic [4:0] ALU_EQ  = 5'b10000;
  localparam logic [4:0] ALU_LT  = 5'b10010;

  // PC source select
  localparam logic [1:0] PCS_MAIS1 = 2'b00;
  localparam logic [1:0] PCS_SALTO = 2'b01;
  localparam logic [1:0] PCS_REG   = 2'b10;
  localparam logic [1:0] PCS_JAL   = 2'b11;

  // register write-data select
  localparam logic [1:0] RWS_ALU = 2'b00;
  localparam logic [1:0] RWS_MEM = 2'b01;
  localparam logic [1:0] RWS_IN  = 2'b10;
  localparam logic [1:0] RWS_PC1 = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_WAIT_IN = 3'd6
  } estado_t;

  // what the FSM needs to remember about the instruction once op/func go stale
  typedef enum logic [3:0] {
    C_NONE   = 4'd0,
    C_ALU    = 4'd1,   // single-cycle ALU op, mov, li, la
    C_MULDIV = 4'd2,
    C_LW     = 4'd3,
    C_SW     = 4'd4,
    C_OUT    = 4'd5,
    C_J      = 4'd6,
    C_JAL    = 4'd7,
    C_JR     = 4'd8,
    C_JF     = 4'd9,
    C_IN     = 4'd10,
    C_HALT   = 4'd11,
    C_NOP    = 4'd12,
    C_INV    = 4'd13
  } classe_t;

endpackage

// File: rtl/unidade_de_controle_multiciclo_decodificador.sv
// Combinational instruction decoder: op/func -> class, ALU control and mux hints.
module decodificador_instrucao
  import unidade_de_controle_multiciclo_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int FUNC_W  = FUNC_W_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  output classe_t            classe,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_reg_alu,
  output logic               is_rt_dest
);

  // anything not listed decodes as C_INV so the FSM drops it without writes
  always_comb begin
    classe     = C_INV;
    alu_op     = '0;
    is_reg_alu = 1'b0;
    is_rt_dest = 1'b0;
    case (op)
      OP_R: begin
        classe     = C_ALU;
        is_reg_alu = 1'b1;
        case (func)
          F_ADD: alu_op = ALUOP_W'(ALU_ADD);
          F_SUB: alu_op = ALUOP_W'(ALU_SUB);
          F_MUL: begin alu_op = ALUOP_W'(ALU_MUL); classe = C_MULDIV; end
          F_DIV: begin alu_op = ALUOP_W'(ALU_DIV); classe = C_MULDIV; end
          F_MOD: begin alu_op = ALUOP_W'(ALU_MOD); classe = C_MULDIV; end
          F_AND: alu_op = ALUOP_W'(ALU_AND);
          F_MOV: begin alu_op = ALUOP_W'(ALU_MOV); is_rt_dest = 1'b1; end
          F_EQ:  alu_op = ALUOP_W'(ALU_EQ);
          F_LT:  alu_op = ALUOP_W'(ALU_LT);
          default: begin classe = C_INV; is_reg_alu = 1'b0; end
        endcase
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_DIVI, OP_MODI, OP_ANDI, OP_EQI, OP_LTI: begin
        classe     = C_ALU;
        is_rt_dest = 1'b1;
        case (op)
          OP_ADDI: alu_op = ALUOP_W'(ALU_ADD);
          OP_SUBI: alu_op = ALUOP_W'(ALU_SUB);
          OP_MULI: begin alu_op = ALUOP_W'(ALU_MUL); classe = C_MULDIV; end
          OP_DIVI: begin alu_op = ALUOP_W'(ALU_DIV); classe = C_MULDIV; end
          OP_MODI: begin alu_op = ALUOP_W'(ALU_MOD); classe = C_MULDIV; end
          OP_ANDI: alu_op = ALUOP_W'(ALU_AND);
          OP_EQI:  alu_op = ALUOP_W'(ALU_EQ);
          default: alu_op = ALUOP_W'(ALU_LT);
        endcase
      end
      // li/la pass the immediate straight through the ALU
      OP_LI, OP_LA: begin classe = C_ALU; alu_op = ALUOP_W'(ALU_MOV); is_rt_dest = 1'b1; end
      OP_LW:   begin classe = C_LW; alu_op = ALUOP_W'(ALU_ADD); is_rt_dest = 1'b1; end
      OP_SW:   begin classe = C_SW; alu_op = ALUOP_W'(ALU_ADD); end
      OP_OUT:  begin classe = C_OUT; alu_op = ALUOP_W'(ALU_MOV); end
      OP_J:    classe = C_J;
      OP_JAL:  classe = C_JAL;
      OP_JR:   classe = C_JR;
      OP_JF:   begin classe = C_JF; is_reg_alu = 1'b1; end
      OP_IN:   begin classe = C_IN; is_rt_dest = 1'b1; end
      OP_HALT: classe = C_HALT;
      OP_NOP:  classe = C_NOP;
      default: classe = C_INV;
    endcase
  end

endmodule

// File: rtl/unidade_de_controle_multiciclo.sv
// Multicycle control FSM for the iZero core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// stretched EXEC for mul/div/mod, HALT and WAIT_IN parking.
module unidade_de_controle_multiciclo
  import unidade_de_controle_multiciclo_pkg::*;
#(
  parameter int OP_W          = OP_W_DEF,
  parameter int FUNC_W        = FUNC_W_DEF,
  parameter int ALUOP_W       = ALUOP_W_DEF,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               resume,
  input  logic               in_valid,
  input  logic               isFalse,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  output logic               pcWrite,
  output logic               irWrite,
  output logic               regWrite,
  output logic               memWrite,
  output logic               outWrite,
  output logic               isRegAluOp,
  output logic               isRTDest,
  output logic               isJal,
  output logic [1:0]         pcSource,
  output logic [1:0]         regWrtSelect,
  output logic [ALUOP_W-1:0] aluOp,
  output logic               halted
);

  estado_t              estado, prox;
  logic [3:0]           contador;
  classe_t              classe_q;
  logic [ALUOP_W-1:0]   aluop_q;
  logic                 reg_alu_q, rt_dest_q;

  classe_t              dec_classe;
  logic [ALUOP_W-1:0]   dec_aluop;
  logic                 dec_reg_alu, dec_rt_dest;

  decodificador_instrucao #(
    .OP_W(OP_W), .FUNC_W(FUNC_W), .ALUOP_W(ALUOP_W)
  ) u_dec (
    .op(op), .func(func),
    .classe(dec_classe), .alu_op(dec_aluop),
    .is_reg_alu(dec_reg_alu), .is_rt_dest(dec_rt_dest)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset) estado <= S_FETCH;
    else        estado <= prox;
  end

  // latch decode results in DECODE and run the mul/div EXEC down-counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      contador  <= '0;
      classe_q  <= C_NONE;
      aluop_q   <= '0;
      reg_alu_q <= 1'b0;
      rt_dest_q <= 1'b0;
    end else if (estado == S_DECODE) begin
      classe_q  <= dec_classe;
      aluop_q   <= dec_aluop;
      reg_alu_q <= dec_reg_alu;
      rt_dest_q <= dec_rt_dest;
      contador  <= (dec_classe == C_MULDIV) ? 4'(MULDIV_CYCLES - 1) : 4'd0;
    end else if (estado == S_EXEC && contador != 4'd0) begin
      contador <= contador - 4'd1;
    end
  end

  assign aluOp      = aluop_q;
  assign isRegAluOp = reg_alu_q;
  assign isRTDest   = rt_dest_q;

  // next state and strobes; only DECODE looks at the raw decoder, outputs use latched class
  always_comb begin
    prox         = estado;
    pcWrite      = 1'b0;
    irWrite      = 1'b0;
    regWrite     = 1'b0;
    memWrite     = 1'b0;
    outWrite     = 1'b0;
    isJal        = 1'b0;
    halted       = 1'b0;
    pcSource     = PCS_MAIS1;
    regWrtSelect = RWS_ALU;
    case (estado)
      S_FETCH: begin
        irWrite = 1'b1;
        pcWrite = 1'b1;
        prox    = S_DECODE;
      end
      S_DECODE: begin
        case (dec_classe)
          C_HALT:                 prox = S_HALT;
          C_IN:                   prox = S_WAIT_IN;
          C_NOP, C_INV, C_NONE:   prox = S_FETCH;
          default:                prox = S_EXEC;
        endcase
      end
      S_EXEC: begin
        prox = S_FETCH;
        case (classe_q)
          C_MULDIV:          prox = (contador == 4'd0) ? S_WB : S_EXEC;
          C_ALU:             prox = S_WB;
          C_LW, C_SW, C_OUT: prox = S_MEM;
          C_J:  begin pcWrite = 1'b1; pcSource = PCS_SALTO; end
          C_JR: begin pcWrite = 1'b1; pcSource = PCS_REG; end
          C_JF: begin pcWrite = isFalse; pcSource = PCS_SALTO; end
          C_JAL: begin
            pcWrite      = 1'b1;
            pcSource     = PCS_JAL;
            regWrite     = 1'b1;
            isJal        = 1'b1;
            regWrtSelect = RWS_PC1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        memWrite = (classe_q == C_SW);
        outWrite = (classe_q == C_OUT);
        prox     = (classe_q == C_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        regWrite = 1'b1;
        if (classe_q == C_LW)      regWrtSelect = RWS_MEM;
        else if (classe_q == C_IN) regWrtSelect = RWS_IN;
        prox = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (resume) prox = S_FETCH;
      end
      S_WAIT_IN: begin
        if (in_valid) prox = S_WB;
      end
      default: prox = S_FETCH;
    endcase
    // while reset is held the core is parked in FETCH and must not load PC/IR
    if (!reset) begin
      pcWrite      = 1'b0;
      irWrite      = 1'b0;
      regWrite     = 1'b0;
      memWrite     = 1'b0;
      outWrite     = 1'b0;
      isJal        = 1'b0;
      halted       = 1'b0;
      pcSource     = PCS_MAIS1;
      regWrtSelect = RWS_ALU;
    end
  end

endmodule
